// File: rtl/instr_mem_bank.sv
// ---------------------------------------------------------------------------
// instr_mem_bank
//   Writable, multi-bank instruction store sitting between the program
//   counter and the instruction decoder. NPROG banks of 2**D words of W bits.
//   A handshaked boot-load FSM fills one bank at run time: it accepts
//   load_len words from the load port and then pads the rest of the bank
//   with NOP_CODE. A registered fetch port reads from the run-selected bank.
//   A fetch from a bank that is out of range, unloaded, or currently being
//   reloaded returns NOP_CODE with code_valid low.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   load_start          one-cycle request to begin loading (ignored while busy)
//   load_bank/load_len  target bank and word count, sampled with load_start
//   ld_valid/ld_data    load word stream
//   ld_ready            load word accepted this cycle when ld_valid is high
//   load_busy           loader is not idle
//   load_done           one-cycle pulse when a bank fill completes
//   load_err            one-cycle pulse after a rejected load_start
//   bank_loaded         per-bank valid flags
//   run_bank/fetch_en/prog_ctr  fetch request
//   mach_code/code_valid        fetched word, one cycle after the request
// ---------------------------------------------------------------------------
module instr_mem_bank #(
  parameter int             W        = 9,
  parameter int             D        = 8,
  parameter int             NPROG    = 3,
  parameter logic [W-1:0]   NOP_CODE = '0,
  parameter int             BW       = (NPROG > 1) ? $clog2(NPROG) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic [BW-1:0]     load_bank,
  input  logic [D:0]        load_len,
  input  logic              ld_valid,
  input  logic [W-1:0]      ld_data,
  output logic              ld_ready,
  output logic              load_busy,
  output logic              load_done,
  output logic              load_err,
  output logic [NPROG-1:0]  bank_loaded,
  input  logic [BW-1:0]     run_bank,
  input  logic              fetch_en,
  input  logic [D-1:0]      prog_ctr,
  output logic [W-1:0]      mach_code,
  output logic              code_valid
);

  localparam int         DEPTH    = 2**D;
  localparam int         NFLAG    = 2**BW;
  localparam logic [D:0] DEPTH_V  = (D+1)'(DEPTH);
  localparam logic [D:0] LAST_V   = (D+1)'(DEPTH - 1);
  localparam logic [D:0] ONE_V    = (D+1)'(1);

  typedef enum logic [1:0] {IDLE, LOAD, FILL, DONE} state_t;

  state_t            state_q, state_d;
  logic [BW-1:0]     bank_q, bank_d;
  logic [D:0]        len_q, len_d;
  logic [D:0]        addr_q, addr_d;   // D+1 bits so 2**D is representable
  logic [D:0]        addr_inc;
  logic [NPROG-1:0]  loaded_q, loaded_d;
  logic              err_d, err_q;
  logic              start_ok;
  logic              wr_en;
  logic [W-1:0]      wr_data;

  logic [W-1:0]      mem [NPROG][DEPTH];

  assign start_ok = (32'(load_bank) < NPROG) && (32'(load_len) <= DEPTH);
  assign addr_inc = addr_q + ONE_V;

  // NOTE: every signal assigned in this block gets a default first, so no
  // path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    bank_d   = bank_q;
    len_d    = len_q;
    addr_d   = addr_q;
    loaded_d = loaded_q;
    err_d    = 1'b0;
    wr_en    = 1'b0;
    wr_data  = ld_data;
    case (state_q)
      IDLE: begin
        if (load_start) begin
          if (start_ok) begin
            bank_d             = load_bank;
            len_d              = load_len;
            addr_d             = '0;
            // Invalidate the target at accept so fetches never see a
            // half-written bank.
            loaded_d[load_bank] = 1'b0;
            state_d            = (load_len == '0) ? FILL : LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (ld_valid) begin
          wr_en  = 1'b1;
          addr_d = addr_inc;
          if (addr_inc == len_q)
            state_d = (addr_inc == DEPTH_V) ? DONE : FILL;
        end
      end
      FILL: begin
        wr_en   = 1'b1;
        wr_data = NOP_CODE;
        addr_d  = addr_inc;
        if (addr_q == LAST_V)
          state_d = DONE;
      end
      DONE: begin
        loaded_d[bank_q] = 1'b1;
        state_d          = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      bank_q   <= '0;
      len_q    <= '0;
      addr_q   <= '0;
      loaded_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bank_q   <= bank_d;
      len_q    <= len_d;
      addr_q   <= addr_d;
      loaded_q <= loaded_d;
      err_q    <= err_d;
    end
  end

  // NOTE: the storage array has no reset; validity is tracked by the
  // bank_loaded flags, which keeps the array mappable onto RAM macros.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[bank_q][addr_q[D-1:0]] <= wr_data;
  end

  assign ld_ready    = (state_q == LOAD);
  assign load_busy   = (state_q != IDLE);
  assign load_done   = (state_q == DONE);
  assign load_err    = err_q;
  assign bank_loaded = loaded_q;

  // Flags padded to the full select range so an out-of-range run_bank
  // reads a zero flag instead of indexing past the vector.
  logic [NFLAG-1:0] flags_ext;
  logic             fetch_hit;

  always_comb begin
    flags_ext            = '0;
    flags_ext[NPROG-1:0] = loaded_q;
  end

  assign fetch_hit = fetch_en && (32'(run_bank) < NPROG) && flags_ext[run_bank];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mach_code  <= NOP_CODE;
      code_valid <= 1'b0;
    end else if (fetch_hit) begin
      mach_code  <= mem[run_bank][prog_ctr];
      code_valid <= 1'b1;
    end else if (fetch_en) begin
      mach_code  <= NOP_CODE;
      code_valid <= 1'b0;
    end else begin
      code_valid <= 1'b0;   // mach_code holds its last value
    end
  end

endmodule

// File: tb/tb_instr_mem_bank.sv
// ---------------------------------------------------------------------------
// tb_instr_mem_bank
//   Directed bench for instr_mem_bank with default parameters
//   (W=9, D=8, NPROG=3, NOP_CODE=0). Fetch expectations live in a vector
//   table; load, error, stall and reset corner cases are hand-written
//   sequences. Inputs are driven and outputs sampled 1 ns after each
//   rising edge.
// ---------------------------------------------------------------------------
module tb_instr_mem_bank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_start;
  logic [1:0]  load_bank;
  logic [8:0]  load_len;
  logic        ld_valid;
  logic [8:0]  ld_data;
  logic        ld_ready;
  logic        load_busy;
  logic        load_done;
  logic        load_err;
  logic [2:0]  bank_loaded;
  logic [1:0]  run_bank;
  logic        fetch_en;
  logic [7:0]  prog_ctr;
  logic [8:0]  mach_code;
  logic        code_valid;

  int n_checks = 0;
  int n_fail   = 0;

  instr_mem_bank dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_start  (load_start),
    .load_bank   (load_bank),
    .load_len    (load_len),
    .ld_valid    (ld_valid),
    .ld_data     (ld_data),
    .ld_ready    (ld_ready),
    .load_busy   (load_busy),
    .load_done   (load_done),
    .load_err    (load_err),
    .bank_loaded (bank_loaded),
    .run_bank    (run_bank),
    .fetch_en    (fetch_en),
    .prog_ctr    (prog_ctr),
    .mach_code   (mach_code),
    .code_valid  (code_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] bank;
    logic [7:0] pc;
    logic [8:0] code;
    logic       valid;
  } fvec_t;

  fvec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_vec(input int i);
    run_bank = vecs[i].bank;
    prog_ctr = vecs[i].pc;
    fetch_en = 1'b1;
    tick();
    check($sformatf("fetch%0d_code", i), 32'(mach_code), 32'(vecs[i].code));
    check($sformatf("fetch%0d_valid", i), 32'(code_valid), 32'(vecs[i].valid));
  endtask

  // Waits for load_done, expecting it after exactly exp_cycles more edges,
  // then checks it drops and the loader returns to idle.
  task automatic wait_done(input string name, input int exp_cycles);
    int cnt = 0;
    while (load_done !== 1'b1 && cnt < 400) begin
      tick();
      cnt++;
    end
    check({name, "_done_seen"}, 32'(load_done), 1);
    check({name, "_fill_cycles"}, 32'(cnt), 32'(exp_cycles));
    tick();
    check({name, "_done_pulse"}, 32'(load_done), 0);
    check({name, "_idle"}, 32'(load_busy), 0);
  endtask

  task automatic start_load(input logic [1:0] bank, input int len);
    load_bank  = bank;
    load_len   = 9'(len);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic do_load(input string name, input logic [1:0] bank, input int len,
                         input logic [8:0] w0, input logic [8:0] w1,
                         input logic [8:0] w2, input logic [8:0] w3);
    logic [8:0] wv [4];
    wv = '{w0, w1, w2, w3};
    start_load(bank, len);
    check({name, "_busy"}, 32'(load_busy), 1);
    check({name, "_flag_cleared"}, 32'(bank_loaded[bank]), 0);
    for (int i = 0; i < len; i++) begin
      ld_valid = 1'b1;
      ld_data  = wv[i % 4];
      check($sformatf("%s_ready%0d", name, i), 32'(ld_ready), 1);
      tick();
    end
    ld_valid = 1'b0;
    check({name, "_ready_low_fill"}, 32'(ld_ready), 0);
    wait_done(name, 256 - len);
  endtask

  initial begin
    // Fetch expectations: bank 1 loaded with 0FE,066,07A,1DE then NOP pad;
    // bank 0 loaded with 155,0AA; bank 2 unloaded until the stall test.
    vecs[0]  = '{2'd1, 8'd0,   9'h0FE, 1'b1};
    vecs[1]  = '{2'd1, 8'd3,   9'h1DE, 1'b1};
    vecs[2]  = '{2'd1, 8'd4,   9'h000, 1'b1};
    vecs[3]  = '{2'd1, 8'd255, 9'h000, 1'b1};
    vecs[4]  = '{2'd1, 8'd1,   9'h066, 1'b1};
    vecs[5]  = '{2'd1, 8'd2,   9'h07A, 1'b1};
    vecs[6]  = '{2'd0, 8'd0,   9'h000, 1'b0};
    vecs[7]  = '{2'd2, 8'd0,   9'h000, 1'b0};
    vecs[8]  = '{2'd3, 8'd0,   9'h000, 1'b0};
    // After bank 2 is loaded with 101..104 across a stall.
    vecs[9]  = '{2'd2, 8'd0,   9'h101, 1'b1};
    vecs[10] = '{2'd2, 8'd1,   9'h102, 1'b1};
    vecs[11] = '{2'd2, 8'd2,   9'h103, 1'b1};
    vecs[12] = '{2'd2, 8'd3,   9'h104, 1'b1};
    vecs[13] = '{2'd2, 8'd4,   9'h000, 1'b1};
    vecs[14] = '{2'd0, 8'd1,   9'h0AA, 1'b1};
    vecs[15] = '{2'd1, 8'd3,   9'h1DE, 1'b1};

    rst_n      = 1'b0;
    load_start = 1'b0;
    load_bank  = '0;
    load_len   = '0;
    ld_valid   = 1'b0;
    ld_data    = '0;
    run_bank   = 2'd0;
    fetch_en   = 1'b1;
    prog_ctr   = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_code",   32'(mach_code), 0);
    check("rst_valid",  32'(code_valid), 0);
    check("rst_flags",  32'(bank_loaded), 0);
    check("rst_busy",   32'(load_busy), 0);
    check("rst_ready",  32'(ld_ready), 0);
    check("rst_err",    32'(load_err), 0);

    do_load("ld_b1", 2'd1, 4, 9'h0FE, 9'h066, 9'h07A, 9'h1DE);
    check("ld_b1_flags", 32'(bank_loaded), 'b010);

    for (int i = 0; i <= 8; i++) apply_vec(i);

    // Hold behaviour: fetch_en low keeps the word, drops valid.
    apply_vec(1);
    fetch_en = 1'b0;
    tick();
    check("hold_code",  32'(mach_code), 'h1DE);
    check("hold_valid", 32'(code_valid), 0);

    // Rejected starts: bank out of range, then length too large.
    start_load(2'd3, 4);
    check("err_bank_pulse", 32'(load_err), 1);
    check("err_bank_idle",  32'(load_busy), 0);
    tick();
    check("err_bank_clear", 32'(load_err), 0);
    start_load(2'd0, 257);
    check("err_len_pulse",  32'(load_err), 1);
    check("err_len_idle",   32'(load_busy), 0);
    check("err_len_flags",  32'(bank_loaded), 'b010);
    tick();
    check("err_len_clear",  32'(load_err), 0);

    do_load("ld_b0", 2'd0, 2, 9'h155, 9'h0AA, 9'h000, 9'h000);
    check("ld_b0_flags", 32'(bank_loaded), 'b011);

    // Bank 2 load with a 5-cycle stall after two words; fetch bank 0 meanwhile.
    start_load(2'd2, 4);
    for (int i = 0; i < 2; i++) begin
      ld_valid = 1'b1;
      ld_data  = 9'(9'h101 + i);
      tick();
    end
    ld_valid = 1'b0;
    fetch_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      run_bank = (k == 3) ? 2'd2 : 2'd0;
      prog_ctr = 8'(k % 2);
      if (k == 2) begin
        load_start = 1'b1;
        load_bank  = 2'd1;
        load_len   = 9'd0;
      end
      tick();
      load_start = 1'b0;
      check($sformatf("stall%0d_ready", k), 32'(ld_ready), 1);
      check($sformatf("stall%0d_busy", k),  32'(load_busy), 1);
      if (k == 3) begin
        check("stall_loading_bank_valid", 32'(code_valid), 0);
        check("stall_loading_bank_code",  32'(mach_code), 0);
      end else begin
        check($sformatf("stall%0d_b0_valid", k), 32'(code_valid), 1);
        check($sformatf("stall%0d_b0_code", k),  32'(mach_code), (k % 2 == 0) ? 'h155 : 'h0AA);
      end
    end
    check("busy_start_no_err", 32'(load_err), 0);
    check("busy_start_flags",  32'(bank_loaded), 'b011);
    for (int i = 2; i < 4; i++) begin
      ld_valid = 1'b1;
      ld_data  = 9'(9'h101 + i);
      tick();
    end
    ld_valid = 1'b0;
    wait_done("ld_b2", 252);
    check("ld_b2_flags", 32'(bank_loaded), 'b111);

    for (int i = 9; i <= 15; i++) apply_vec(i);

    // Reset during FILL of bank 2; mach_code holds 1DE beforehand.
    fetch_en = 1'b0;
    start_load(2'd2, 0);
    tick();
    tick();
    check("fill_busy", 32'(load_busy), 1);
    rst_n = 1'b0;
    #1;
    check("midrst_flags", 32'(bank_loaded), 0);
    check("midrst_code",  32'(mach_code), 0);
    check("midrst_busy",  32'(load_busy), 0);
    tick();
    rst_n = 1'b1;
    run_bank = 2'd2;
    prog_ctr = 8'd0;
    fetch_en = 1'b1;
    tick();
    check("post_rst_b2_valid", 32'(code_valid), 0);
    check("post_rst_done",     32'(load_done), 0);
    run_bank = 2'd1;
    tick();
    check("post_rst_b1_valid", 32'(code_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
